// File: rtl/tx_arbiter_rr.sv
// tx_arbiter_rr: shares one serial transmitter between N_REQ requesters.
// A winner is picked round-robin, its payload/length/destination are
// captured and held on tx_* for the whole frame, tx_start is pulsed once,
// and done/err is returned to the owner after the frame or on a timeout.
// An inter-frame gap of IFG_CYCLES idle cycles follows every sent frame.
// Optional build macro: TX_ARB_PRIO0_EN -- requester 0 gets fixed priority
// and the remaining requesters rotate among themselves.
module tx_arbiter_rr #(
  parameter int N_REQ      = 4,
  parameter int IFG_CYCLES = 12,
  parameter int BUSY_TO    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*128-1:0] req_data,
  input  logic [N_REQ*4-1:0]   req_len,
  input  logic [N_REQ*2-1:0]   req_dest,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     err,
  output logic                 tx_start,
  output logic [127:0]         tx_data,
  output logic [3:0]           tx_len,
  output logic [1:0]           tx_dest_id,
  input  logic                 tx_busy,
  output logic                 arb_busy,
  output logic [1:0]           cur_id
);

  // Counter widths follow $clog2(max)+1 so the terminal value always fits.
  localparam int GAP_W = $clog2((IFG_CYCLES > 0) ? IFG_CYCLES : 1) + 1;
  localparam int TO_W  = $clog2((BUSY_TO > 0) ? BUSY_TO : 1) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;
  localparam logic [GAP_W-1:0] GAP_MAX  = '1;
  localparam logic [TO_W-1:0]  TO_LAST  = (BUSY_TO > 0) ? TO_W'(BUSY_TO - 1) : '0;
  localparam logic [TO_W-1:0]  TO_MAX   = '1;

`ifdef TX_ARB_PRIO0_EN
  // Requester 0 is served by priority, so the rotation pointer skips it.
  localparam logic [1:0] RR_RESET = 2'd1;
`else
  localparam logic [1:0] RR_RESET = 2'd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WBUSY = 3'd2,
    S_WDONE = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [1:0]         rr_ptr_r;
  logic [1:0]         rr_next_s;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic [TO_W-1:0]    to_cnt_r;
  logic               found_s;
  logic [1:0]         win_id_s;
  logic [127:0]       sel_data_s;
  logic [3:0]         sel_len_s;
  logic [1:0]         sel_dest_s;
  logic               capture_s;
  logic [N_REQ-1:0]   gnt_s;
  logic [N_REQ-1:0]   done_s;
  logic [N_REQ-1:0]   err_s;
  logic               start_s;
  logic [127:0]       tx_data_r;
  logic [3:0]         tx_len_r;
  logic [1:0]         tx_dest_r;
  logic [1:0]         cur_id_r;

  // Decode a 2-bit requester index into a one-hot requester vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] id);
    logic [N_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (id == 2'(i)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = v[i];
      end
    end
    return v;
  endfunction

  // Find the winning requester and the pointer value that follows it.
  always_comb begin : arb_search
    int idx_v;
    idx_v     = 0;
    found_s   = 1'b0;
    win_id_s  = 2'd0;
    rr_next_s = rr_ptr_r;
`ifdef TX_ARB_PRIO0_EN
    if (req[0]) begin
      found_s  = 1'b1;
      win_id_s = 2'd0;
    end else begin
      for (int k = 0; k < N_REQ - 1; k++) begin
        idx_v = 1 + ((int'(rr_ptr_r) - 1 + k) % (N_REQ - 1));
        if (!found_s && req[2'(idx_v)]) begin
          found_s  = 1'b1;
          win_id_s = 2'(idx_v);
        end else begin
          found_s = found_s;
        end
      end
    end
    // A priority win leaves the rotation among 1..N_REQ-1 untouched.
    if (win_id_s == 2'd0) begin
      rr_next_s = rr_ptr_r;
    end else if (int'(win_id_s) + 1 >= N_REQ) begin
      rr_next_s = 2'd1;
    end else begin
      rr_next_s = win_id_s + 2'd1;
    end
`else
    for (int k = 0; k < N_REQ; k++) begin
      idx_v = (int'(rr_ptr_r) + k) % N_REQ;
      if (!found_s && req[2'(idx_v)]) begin
        found_s  = 1'b1;
        win_id_s = 2'(idx_v);
      end else begin
        found_s = found_s;
      end
    end
    rr_next_s = 2'((int'(win_id_s) + 1) % N_REQ);
`endif
  end

  // Multiplex the winner's payload, length and destination.
  always_comb begin
    sel_data_s = 128'd0;
    sel_len_s  = 4'd0;
    sel_dest_s = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id_s == 2'(i)) begin
        sel_data_s = req_data[i*128 +: 128];
        sel_len_s  = req_len[i*4 +: 4];
        sel_dest_s = req_dest[i*2 +: 2];
      end else begin
        sel_len_s = sel_len_s;
      end
    end
  end

  // Next state and per-cycle pulses; nothing is issued while rst is high.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    gnt_s     = '0;
    done_s    = '0;
    err_s     = '0;
    start_s   = 1'b0;
    if (rst) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (found_s) begin
            capture_s = 1'b1;
            gnt_s     = onehot(win_id_s);
            if (sel_len_s == 4'd0) begin
              err_s = onehot(win_id_s);
            end else begin
              state_s = S_START;
            end
          end else begin
            state_s = S_IDLE;
          end
        end
        S_START: begin
          start_s = 1'b1;
          state_s = S_WBUSY;
        end
        S_WBUSY: begin
          // Transmitter never answered: hand the error back, skip the gap.
          if (tx_busy) begin
            state_s = S_WDONE;
          end else if (to_cnt_r >= TO_LAST) begin
            err_s   = onehot(cur_id_r);
            state_s = S_IDLE;
          end else begin
            state_s = S_WBUSY;
          end
        end
        S_WDONE: begin
          // Only a fall seen here ends the frame; earlier glitches are ignored.
          if (!tx_busy) begin
            done_s  = onehot(cur_id_r);
            state_s = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            state_s = S_WDONE;
          end
        end
        S_GAP: begin
          if ((IFG_CYCLES == 0) || (gap_cnt_r >= GAP_LAST)) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_GAP;
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // State register, saturating counters, pointer and captured frame fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      rr_ptr_r  <= RR_RESET;
      gap_cnt_r <= '0;
      to_cnt_r  <= '0;
      tx_data_r <= 128'd0;
      tx_len_r  <= 4'd0;
      tx_dest_r <= 2'd0;
      cur_id_r  <= 2'd0;
    end else begin
      state_r <= state_s;
      if (state_r == S_WBUSY) begin
        to_cnt_r <= (to_cnt_r == TO_MAX) ? to_cnt_r : to_cnt_r + TO_W'(1);
      end else begin
        to_cnt_r <= '0;
      end
      if (state_r == S_GAP) begin
        gap_cnt_r <= (gap_cnt_r == GAP_MAX) ? gap_cnt_r : gap_cnt_r + GAP_W'(1);
      end else begin
        gap_cnt_r <= '0;
      end
      if (capture_s) begin
        tx_data_r <= sel_data_s;
        tx_len_r  <= sel_len_s;
        tx_dest_r <= sel_dest_s;
        cur_id_r  <= win_id_s;
        rr_ptr_r  <= rr_next_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  assign gnt        = gnt_s;
  assign done       = done_s;
  assign err        = err_s;
  assign tx_start   = start_s;
  assign tx_data    = tx_data_r;
  assign tx_len     = tx_len_r;
  assign tx_dest_id = tx_dest_r;
  assign arb_busy   = (state_r != S_IDLE);
  assign cur_id     = cur_id_r;

endmodule
